// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
// Holds the FSM state encoding, register-index and stall-counter widths,
// the packed control-output bundle with its canonical values, and a
// saturating-increment helper for the stall counter.
package pipeline_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_e;

    localparam int REG_IDX_W   = 4;
    localparam int STALL_CNT_W = 16;
    localparam int MD_CNT_W    = 4;

    localparam logic [REG_IDX_W-1:0]   ZERO_REG      = 4'd0;
    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = 16'hFFFF;

    // One bundle for every pipeline-control output, so each priority
    // branch assigns a single named value.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic id_ex_hold;
        logic ex_mem_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_DEFAULT  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam ctrl_t CTRL_RESET    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    localparam ctrl_t CTRL_MD_STALL = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam ctrl_t CTRL_BRANCH   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam ctrl_t CTRL_RAW      = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Increment that sticks at the maximum instead of wrapping.
    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] value);
        if (value == STALL_CNT_MAX) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle of hazard-detection inputs and pipeline-control outputs exchanged
// between the datapath (master) and the pipeline controller (slave).
//   master: drives ID/EX/MEM stage info, observes control outputs
//   slave : observes stage info, drives pcWrite..exMemBubble and stallCount
interface pipeline_ctrl_if;
    import pipeline_ctrl_pkg::*;

    logic [REG_IDX_W-1:0]   idRs;
    logic [REG_IDX_W-1:0]   idRt;
    logic                   idUsesRs;
    logic                   idUsesRt;
    logic [REG_IDX_W-1:0]   exRd;
    logic                   exRegWrite;
    logic                   exMemRead;
    logic [REG_IDX_W-1:0]   memRd;
    logic                   memRegWrite;
    logic                   exMultiCycle;
    logic                   branchTaken;

    logic                   pcWrite;
    logic                   ifIdWrite;
    logic                   ifIdFlush;
    logic                   idExFlush;
    logic                   idExHold;
    logic                   exMemBubble;
    logic [STALL_CNT_W-1:0] stallCount;

    modport master (
        output idRs, idRt, idUsesRs, idUsesRt, exRd, exRegWrite, exMemRead,
               memRd, memRegWrite, exMultiCycle, branchTaken,
        input  pcWrite, ifIdWrite, ifIdFlush, idExFlush, idExHold,
               exMemBubble, stallCount
    );

    modport slave (
        input  idRs, idRt, idUsesRs, idUsesRt, exRd, exRegWrite, exMemRead,
               memRd, memRegWrite, exMultiCycle, branchTaken,
        output pcWrite, ifIdWrite, ifIdFlush, idExFlush, idExHold,
               exMemBubble, stallCount
    );

endinterface

// File: rtl/pipeline_ctrl_raw_match.sv
// raw_match: combinational read-after-write comparator for one producing
// stage. Flags a match when the producer writes a non-zero register that
// the ID-stage instruction actually reads.
//   dst, dst_wr        : producer destination index and write enable
//   rs, rt             : ID-stage source indices
//   uses_rs, uses_rt   : ID-stage instruction reads that source
//   match              : hazard against this producer
module raw_match
    import pipeline_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] dst,
    input  logic                 dst_wr,
    input  logic [REG_IDX_W-1:0] rs,
    input  logic [REG_IDX_W-1:0] rt,
    input  logic                 uses_rs,
    input  logic                 uses_rt,
    output logic                 match
);

    logic rs_hit_s;
    logic rt_hit_s;

    // Register 0 is hard-wired, so writes to it never create a dependency.
    always_comb begin
        rs_hit_s = uses_rs && (rs == dst);
        rt_hit_s = uses_rt && (rt == dst);
        match    = (dst != ZERO_REG) && dst_wr && (rs_hit_s || rt_hit_s);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush controller for a 5-stage in-order pipeline.
// Handles multi-cycle EX ops (FSM RUN/MD_WAIT with a down-counter), taken
// branches and RAW hazards, and keeps a saturating count of stall cycles.
// Outputs are combinational from state, counter and inputs so they are
// settled before the falling edge on which the pipeline registers capture.
//
// Ports:
//   clock : rising-edge controller clock
//   reset : synchronous, active-low
//   bus   : pipeline_ctrl_if.slave (stage info in, control + stallCount out)
// Parameter:
//   MD_LATENCY : total EX cycles of a multi-cycle op, legal range 2..15
// Build option:
//   FORWARDING_EN : when defined, only load-use hazards stall; otherwise any
//                   EX or MEM destination match stalls.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = 4
) (
    input  logic           clock,
    input  logic           reset,
    pipeline_ctrl_if.slave bus
);

    // The stall cycle that enters MD_WAIT is already one of the op's cycles,
    // and the final MD_WAIT cycle (cnt==0) releases the pipe, hence -2.
    localparam logic [MD_CNT_W-1:0] MD_CNT_INIT = MD_CNT_W'(MD_LATENCY - 2);

    state_e                 state_r;
    state_e                 state_nxt_s;
    logic [MD_CNT_W-1:0]    cnt_r;
    logic [MD_CNT_W-1:0]    cnt_nxt_s;
    logic [STALL_CNT_W-1:0] stall_cnt_r;
    logic                   ex_match_s;
    logic                   mem_match_s;
    logic                   raw_stall_s;
    ctrl_t                  ctrl_s;

    raw_match u_ex_match (
        .dst     (bus.exRd),
        .dst_wr  (bus.exRegWrite),
        .rs      (bus.idRs),
        .rt      (bus.idRt),
        .uses_rs (bus.idUsesRs),
        .uses_rt (bus.idUsesRt),
        .match   (ex_match_s)
    );

    raw_match u_mem_match (
        .dst     (bus.memRd),
        .dst_wr  (bus.memRegWrite),
        .rs      (bus.idRs),
        .rt      (bus.idRt),
        .uses_rs (bus.idUsesRs),
        .uses_rt (bus.idUsesRt),
        .match   (mem_match_s)
    );

`ifdef FORWARDING_EN
    // With bypass paths only a load in EX cannot be forwarded in time.
    assign raw_stall_s = bus.exMemRead & ex_match_s;
`else
    // Without bypass paths any in-flight producer must drain first.
    assign raw_stall_s = ex_match_s | mem_match_s;
`endif

    // State and counter register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= RUN;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic; only exMultiCycle matters in RUN, nothing in MD_WAIT.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            RUN: begin
                if (bus.exMultiCycle) begin
                    state_nxt_s = MD_WAIT;
                    cnt_nxt_s   = MD_CNT_INIT;
                end else begin
                    state_nxt_s = RUN;
                    cnt_nxt_s   = cnt_r;
                end
            end
            MD_WAIT: begin
                if (cnt_r != 4'd0) begin
                    state_nxt_s = MD_WAIT;
                    cnt_nxt_s   = cnt_r - 4'd1;
                end else begin
                    state_nxt_s = RUN;
                    cnt_nxt_s   = 4'd0;
                end
            end
            default: begin
                state_nxt_s = RUN;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Output logic in strict priority: reset, MD_WAIT, multi-cycle start,
    // branch (overrides RAW), RAW stall, default.
    always_comb begin
        ctrl_s = CTRL_DEFAULT;
        if (!reset) begin
            ctrl_s = CTRL_RESET;
        end else if (state_r == MD_WAIT) begin
            if (cnt_r != 4'd0) begin
                ctrl_s = CTRL_MD_STALL;
            end else begin
                ctrl_s = CTRL_DEFAULT;
            end
        end else if (bus.exMultiCycle) begin
            ctrl_s = CTRL_MD_STALL;
        end else if (bus.branchTaken) begin
            ctrl_s = CTRL_BRANCH;
        end else if (raw_stall_s) begin
            ctrl_s = CTRL_RAW;
        end else begin
            ctrl_s = CTRL_DEFAULT;
        end
    end

    // Stall-cycle counter: counts every non-reset cycle with the PC frozen.
    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_cnt_r <= 16'd0;
        end else if (!ctrl_s.pc_write) begin
            stall_cnt_r <= sat_inc(stall_cnt_r);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign bus.pcWrite     = ctrl_s.pc_write;
    assign bus.ifIdWrite   = ctrl_s.if_id_write;
    assign bus.ifIdFlush   = ctrl_s.if_id_flush;
    assign bus.idExFlush   = ctrl_s.id_ex_flush;
    assign bus.idExHold    = ctrl_s.id_ex_hold;
    assign bus.exMemBubble = ctrl_s.ex_mem_bubble;
    assign bus.stallCount  = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl. Each scenario task builds a list
// of per-cycle steps; expected control vectors and stall counts are pushed
// to a scoreboard queue as stimulus is driven and popped for comparison.
// Inputs change 1 time unit after the rising edge, control outputs are
// sampled on the falling edge, stallCount 1 unit after the next rising edge.
module tb_pipeline_ctrl;

    localparam int LAT = 4;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // {pcWrite, ifIdWrite, ifIdFlush, idExFlush, idExHold, exMemBubble}
    localparam logic [5:0] C_DEF = 6'b110000;
    localparam logic [5:0] C_RST = 6'b001101;
    localparam logic [5:0] C_MD  = 6'b000011;
    localparam logic [5:0] C_BR  = 6'b111100;
    localparam logic [5:0] C_RAW = 6'b000100;

    typedef struct packed {
        logic [3:0] id_rs;
        logic [3:0] id_rt;
        logic       uses_rs;
        logic       uses_rt;
        logic [3:0] ex_rd;
        logic       ex_wr;
        logic       ex_mem_read;
        logic [3:0] mem_rd;
        logic       mem_wr;
        logic       multi;
        logic       branch;
    } stim_t;

    typedef struct packed {
        logic       rst;
        stim_t      s;
        logic [5:0] c;
    } step_t;

    typedef struct packed {
        logic [5:0]  ctl;
        logic [15:0] cnt;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] model_cnt = 16'd0;

    pipeline_ctrl_if bus ();

    pipeline_ctrl #(.MD_LATENCY(LAT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic stim_t mk(input logic [3:0] rs, input logic [3:0] rt,
                                 input logic urs, input logic urt,
                                 input logic [3:0] exrd, input logic exwr, input logic exmr,
                                 input logic [3:0] memrd, input logic memwr,
                                 input logic multi, input logic br);
        stim_t s;
        s = '{rs, rt, urs, urt, exrd, exwr, exmr, memrd, memwr, multi, br};
        return s;
    endfunction

    function automatic step_t step(input logic rst, input stim_t s, input logic [5:0] c);
        step_t t;
        t = '{rst, s, c};
        return t;
    endfunction

    function automatic logic [5:0] obs_ctl();
        return {bus.pcWrite, bus.ifIdWrite, bus.ifIdFlush,
                bus.idExFlush, bus.idExHold, bus.exMemBubble};
    endfunction

    task automatic apply(input logic rst, input stim_t s);
        reset            = rst;
        bus.idRs         = s.id_rs;
        bus.idRt         = s.id_rt;
        bus.idUsesRs     = s.uses_rs;
        bus.idUsesRt     = s.uses_rt;
        bus.exRd         = s.ex_rd;
        bus.exRegWrite   = s.ex_wr;
        bus.exMemRead    = s.ex_mem_read;
        bus.memRd        = s.mem_rd;
        bus.memRegWrite  = s.mem_wr;
        bus.exMultiCycle = s.multi;
        bus.branchTaken  = s.branch;
    endtask

    // Scoreboard push: stall count follows from the expected pcWrite.
    task automatic push_exp(input logic rst, input logic [5:0] c);
        if (!rst) begin
            model_cnt = 16'd0;
        end else if (!c[5] && model_cnt != 16'hFFFF) begin
            model_cnt = model_cnt + 16'd1;
        end
        exp_q.push_back('{c, model_cnt});
    endtask

    stim_t IDLE;
    stim_t LOAD_USE;
    stim_t NOISE;

    task automatic test_reset();
        step_t seq[$];
        exp_t  e;
        seq.push_back(step(1'b0, NOISE, C_RST));
        seq.push_back(step(1'b0, NOISE, C_RST));
        seq.push_back(step(1'b1, IDLE,  C_DEF));
        foreach (seq[i]) begin
            apply(seq[i].rst, seq[i].s);
            push_exp(seq[i].rst, seq[i].c);
            @(negedge clock);
            e = exp_q.pop_front();
            n_checks++;
            if (obs_ctl() !== e.ctl) begin
                n_fail++;
                $display("FAIL reset_ctl[%0d] got=%b want=%b", i, obs_ctl(), e.ctl);
            end
            @(posedge clock); #1;
            n_checks++;
            if (bus.stallCount !== e.cnt) begin
                n_fail++;
                $display("FAIL reset_cnt[%0d] got=%0d want=%0d", i, bus.stallCount, e.cnt);
            end
        end
    endtask

    task automatic test_load_use();
        step_t seq[$];
        exp_t  e;
        seq.push_back(step(1'b1, LOAD_USE, C_RAW));
        seq.push_back(step(1'b1, IDLE, C_DEF));
        // Zero-register destination never stalls.
        seq.push_back(step(1'b1, mk(4'd5, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0), C_DEF));
        // Source not read, and producer not writing: no stall.
        seq.push_back(step(1'b1, mk(4'd5, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0), C_DEF));
        seq.push_back(step(1'b1, mk(4'd5, 4'd0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0), C_DEF));
        // Load-use through rt.
        seq.push_back(step(1'b1, mk(4'd0, 4'd9, 1'b0, 1'b1, 4'd9, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0), C_RAW));
        seq.push_back(step(1'b1, IDLE, C_DEF));
        foreach (seq[i]) begin
            apply(seq[i].rst, seq[i].s);
            push_exp(seq[i].rst, seq[i].c);
            @(negedge clock);
            e = exp_q.pop_front();
            n_checks++;
            if (obs_ctl() !== e.ctl) begin
                n_fail++;
                $display("FAIL load_use_ctl[%0d] got=%b want=%b", i, obs_ctl(), e.ctl);
            end
            @(posedge clock); #1;
            n_checks++;
            if (bus.stallCount !== e.cnt) begin
                n_fail++;
                $display("FAIL load_use_cnt[%0d] got=%0d want=%0d", i, bus.stallCount, e.cnt);
            end
        end
    endtask

    task automatic test_forwarding();
        step_t seq[$];
        exp_t  e;
        // MEM-stage match on rt.
        seq.push_back(step(1'b1, mk(4'd0, 4'd7, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0), FWD ? C_DEF : C_RAW));
        // EX-stage match that is not a load.
        seq.push_back(step(1'b1, mk(4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0), FWD ? C_DEF : C_RAW));
        // MEM producer not writing, and MEM producer targeting r0.
        seq.push_back(step(1'b1, mk(4'd0, 4'd7, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0), C_DEF));
        seq.push_back(step(1'b1, mk(4'd0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0), C_DEF));
        seq.push_back(step(1'b1, IDLE, C_DEF));
        foreach (seq[i]) begin
            apply(seq[i].rst, seq[i].s);
            push_exp(seq[i].rst, seq[i].c);
            @(negedge clock);
            e = exp_q.pop_front();
            n_checks++;
            if (obs_ctl() !== e.ctl) begin
                n_fail++;
                $display("FAIL fwd_ctl[%0d] got=%b want=%b", i, obs_ctl(), e.ctl);
            end
            @(posedge clock); #1;
            n_checks++;
            if (bus.stallCount !== e.cnt) begin
                n_fail++;
                $display("FAIL fwd_cnt[%0d] got=%0d want=%0d", i, bus.stallCount, e.cnt);
            end
        end
    endtask

    task automatic test_branch();
        step_t seq[$];
        exp_t  e;
        stim_t br_hz;
        br_hz        = LOAD_USE;
        br_hz.branch = 1'b1;
        seq.push_back(step(1'b1, br_hz, C_BR));
        seq.push_back(step(1'b1, mk(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1), C_BR));
        seq.push_back(step(1'b1, IDLE, C_DEF));
        foreach (seq[i]) begin
            apply(seq[i].rst, seq[i].s);
            push_exp(seq[i].rst, seq[i].c);
            @(negedge clock);
            e = exp_q.pop_front();
            n_checks++;
            if (obs_ctl() !== e.ctl) begin
                n_fail++;
                $display("FAIL branch_ctl[%0d] got=%b want=%b", i, obs_ctl(), e.ctl);
            end
            @(posedge clock); #1;
            n_checks++;
            if (bus.stallCount !== e.cnt) begin
                n_fail++;
                $display("FAIL branch_cnt[%0d] got=%0d want=%0d", i, bus.stallCount, e.cnt);
            end
        end
    endtask

    // Multi-cycle op with competing inputs held during MD_WAIT; they must be
    // ignored. A second op starts right after the first completes.
    task automatic test_multicycle();
        step_t seq[$];
        exp_t  e;
        stim_t pulse;
        pulse       = IDLE;
        pulse.multi = 1'b1;
        for (int op = 0; op < 2; op++) begin
            seq.push_back(step(1'b1, pulse, C_MD));
            for (int k = 0; k < LAT - 2; k++) begin
                seq.push_back(step(1'b1, NOISE, C_MD));
            end
            seq.push_back(step(1'b1, (op == 0) ? NOISE : IDLE, C_DEF));
        end
        seq.push_back(step(1'b1, IDLE, C_DEF));
        foreach (seq[i]) begin
            apply(seq[i].rst, seq[i].s);
            push_exp(seq[i].rst, seq[i].c);
            @(negedge clock);
            e = exp_q.pop_front();
            n_checks++;
            if (obs_ctl() !== e.ctl) begin
                n_fail++;
                $display("FAIL md_ctl[%0d] got=%b want=%b", i, obs_ctl(), e.ctl);
            end
            @(posedge clock); #1;
            n_checks++;
            if (bus.stallCount !== e.cnt) begin
                n_fail++;
                $display("FAIL md_cnt[%0d] got=%0d want=%0d", i, bus.stallCount, e.cnt);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        step_t seq[$];
        exp_t  e;
        stim_t pulse;
        pulse       = IDLE;
        pulse.multi = 1'b1;
        seq.push_back(step(1'b1, pulse, C_MD));
        seq.push_back(step(1'b1, IDLE, C_MD));
        seq.push_back(step(1'b0, IDLE, C_RST));
        seq.push_back(step(1'b1, IDLE, C_DEF));
        seq.push_back(step(1'b1, LOAD_USE, C_RAW));
        seq.push_back(step(1'b1, IDLE, C_DEF));
        foreach (seq[i]) begin
            apply(seq[i].rst, seq[i].s);
            push_exp(seq[i].rst, seq[i].c);
            @(negedge clock);
            e = exp_q.pop_front();
            n_checks++;
            if (obs_ctl() !== e.ctl) begin
                n_fail++;
                $display("FAIL rst_mid_ctl[%0d] got=%b want=%b", i, obs_ctl(), e.ctl);
            end
            @(posedge clock); #1;
            n_checks++;
            if (bus.stallCount !== e.cnt) begin
                n_fail++;
                $display("FAIL rst_mid_cnt[%0d] got=%0d want=%0d", i, bus.stallCount, e.cnt);
            end
        end
    endtask

    initial begin
        IDLE     = mk(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        LOAD_USE = mk(4'd5, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        NOISE    = mk(4'd5, 4'd6, 1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 4'd6, 1'b1, 1'b1, 1'b1);
        apply(1'b0, IDLE);

        test_reset();
        test_load_use();
        test_forwarding();
        test_branch();
        test_multicycle();
        test_reset_mid_op();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
